pipe_hazard_scoreboard: RTL and testbench
=========================================

// Module: pipe_hazard_scoreboard
// PURPOSE
//   Parametrised hazard/issue controller between IF/ID and ID/EX of the pipelined CPU.
//   Tracks register writes in flight over DEPTH stages and stalls dependent instructions.
//   Inserts a fixed shadow of BR_SHADOW stall cycles after every issued branch.
//   On an error pulse, clears in-flight state and returns the restart PC of the oldest
//   in-flight instruction. Also keeps a saturating stall-cycle counter.
// PARAMETERS
//   AW           5    register address width; NREGS = 2**AW
//   PCW          32   PC width
//   DEPTH        3    stages (>=1) a result stays unavailable after issue
//   BR_SHADOW    3    stall cycles after an issued branch (0 = none)
//   STALL_CNT_W  16   width of the stall counter
// PORTS
//   clk          in   1       rising-edge clock
//   arst_n       in   1       asynchronous reset, active low
//   id_valid     in   1       decode stage holds a real instruction
//   id_rs        in   AW      source register A
//   id_rt        in   AW      source register B
//   id_use_rs    in   1       instruction reads id_rs
//   id_use_rt    in   1       instruction reads id_rt
//   id_wr        in   1       instruction writes id_rd
//   id_rd        in   AW      destination register
//   id_branch    in   1       instruction is a branch
//   id_pc        in   PCW     PC of the decode instruction
//   err          in   1       error detected (1-cycle pulse)
//   issue        out  1       instruction enters EX this cycle
//   stall        out  1       hold PC and IF/ID; send a bubble (NOP) to EX
//   replay_valid out  1       one-cycle pulse: restart fetch at replay_pc
//   replay_pc    out  PCW     restart PC, valid while replay_valid = 1
//   busy_vec     out  2**AW   bit r = write to r still in flight; bit 0 is always 0
//   stall_cnt    out  STALL_CNT_W  number of cycles with stall & id_valid, saturating
// BEHAVIOUR
//   - Reset (async, arst_n=0): all entries invalid, FSM=RUN, shadow counter 0.
//     issue, stall, replay_valid, busy_vec, stall_cnt = 0; replay_pc = 0.
//   - Scoreboard: shift chain E[0..DEPTH-1] of {v, wr, rd, pc}, shifted every cycle.
//     E[0] <= issued instr ({1, id_wr & (id_rd!=0), id_rd, id_pc}), else a bubble (v=0).
//     E[DEPTH-1] drops off the end.
//   - hazard = id_valid & any valid E[k] with wr=1 and a matching rd:
//     (id_use_rs & rd==id_rs) | (id_use_rt & rd==id_rt). Register 0 never matches.
//   - issue and stall are combinational from the current inputs and state.
//     RUN: issue = id_valid & ~hazard & ~err; stall = id_valid & (hazard | err).
//     SHADOW: issue = 0; stall = 1.
//     REPLAY: issue = 0; stall = 1.
//   - Dependent instruction issued at cycle t: the consumer stalls t+1..t+DEPTH and
//     issues at t+DEPTH+1.
//   - FSM transitions:
//     RUN->SHADOW: issue & id_branch & BR_SHADOW>0; counter <= BR_SHADOW.
//     SHADOW: counter decrements each cycle; goes to RUN in the cycle after it reaches 1.
//     So there are exactly BR_SHADOW stall cycles after the branch issues.
//     Any state->REPLAY: on err=1.
//   - err handling (same cycle):
//     - replay_pc <= pc of the highest-index valid entry; if none valid, id_pc.
//     - All entries are cleared at the same edge; the shadow counter is cleared.
//     - Next cycle: FSM=REPLAY, replay_valid=1, busy_vec=0.
//     - The following cycle: RUN.
//     - err during REPLAY restarts REPLAY with replay_pc = id_pc.
//   - Simultaneous err and branch/dependent issue: err wins; nothing is issued.
//   - busy_vec is the OR of one-hot(rd) over valid entries with wr=1.
//   - stall_cnt increments when stall & id_valid and holds at all-ones (no wrap).
// TESTING
//   1. DEPTH=3: issue id_wr rd=3 at t; next instr id_use_rs rs=3
//      -> stall=1 at t+1..t+3, issue=1 at t+4; busy_vec[3]=1 for t+1..t+3.
//   2. Issue id_wr rd=0, then an instr reading r0 -> no stall; busy_vec stays 0.
//   3. Issue branch at t, BR_SHADOW=3, id_valid held -> stall at t+1..t+3, issue at t+4.
//   4. Issue pcs 0x10, 0x14, 0x18 (non-dependent), then err
//      -> next cycle replay_valid=1, replay_pc=0x10, busy_vec=0; one cycle later RUN.
//   5. err in the same cycle as branch issue -> issue=0, no SHADOW; REPLAY then RUN.
//   6. STALL_CNT_W=4, 20 hazard stall cycles -> stall_cnt=15 and holds.
//      Drop arst_n mid-stall -> every output 0 immediately (async).

Source files
------------

// File: rtl/pipe_hazard_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_hazard_scoreboard: RAW/branch-shadow issue control with err replay  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pipe_hazard_scoreboard #(
  parameter int AW          = 5,
  parameter int PCW         = 32,
  parameter int DEPTH       = 3,
  parameter int BR_SHADOW   = 3,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   id_valid,
  input  logic [AW-1:0]          id_rs,
  input  logic [AW-1:0]          id_rt,
  input  logic                   id_use_rs,
  input  logic                   id_use_rt,
  input  logic                   id_wr,
  input  logic [AW-1:0]          id_rd,
  input  logic                   id_branch,
  input  logic [PCW-1:0]         id_pc,
  input  logic                   err,
  output logic                   issue,
  output logic                   stall,
  output logic                   replay_valid,
  output logic [PCW-1:0]         replay_pc,
  output logic [(2**AW)-1:0]     busy_vec,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int NREGS = 2**AW;
  localparam int SHW   = (BR_SHADOW < 2) ? 1 : $clog2(BR_SHADOW + 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SHADOW = 2'd1,
    ST_REPLAY = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [SHW-1:0]         shadow_cnt_q, shadow_cnt_d;
  logic [DEPTH-1:0]       v_q, v_d;
  logic [DEPTH-1:0]       wr_q, wr_d;
  logic [AW-1:0]          rd_q [DEPTH];
  logic [AW-1:0]          rd_d [DEPTH];
  logic [PCW-1:0]         pc_q [DEPTH];
  logic [PCW-1:0]         pc_d [DEPTH];
  logic [PCW-1:0]         replay_pc_q, replay_pc_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic                   hazard;
  logic [PCW-1:0]         oldest_pc;
  logic [NREGS-1:0]       busy_w;
  logic                   issue_w;
  logic                   stall_w;

  // Later (older) entries override earlier ones, so oldest_pc ends on the
  // highest-index valid entry.
  always_comb begin
    hazard    = 1'b0;
    oldest_pc = id_pc;
    busy_w    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (v_q[k] && wr_q[k]) begin
        busy_w[rd_q[k]] = 1'b1;
        if ((id_use_rs && (rd_q[k] == id_rs)) || (id_use_rt && (rd_q[k] == id_rt))) begin
          hazard = 1'b1;
        end
      end
      if (v_q[k]) begin
        oldest_pc = pc_q[k];
      end
    end
    hazard = hazard & id_valid;
  end

  always_comb begin
    state_d      = state_q;
    shadow_cnt_d = shadow_cnt_q;
    replay_pc_d  = replay_pc_q;
    issue_w      = 1'b0;
    stall_w      = 1'b0;
    case (state_q)
      ST_RUN: begin
        issue_w = id_valid & ~hazard & ~err;
        stall_w = id_valid & (hazard | err);
        if (issue_w && id_branch && (BR_SHADOW > 0)) begin
          state_d      = ST_SHADOW;
          shadow_cnt_d = SHW'(BR_SHADOW);
        end
      end
      ST_SHADOW: begin
        stall_w      = 1'b1;
        shadow_cnt_d = shadow_cnt_q - SHW'(1);
        if (shadow_cnt_q <= SHW'(1)) begin
          state_d = ST_RUN;
        end
      end
      ST_REPLAY: begin
        stall_w = 1'b1;
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    if (err) begin
      state_d      = ST_REPLAY;
      shadow_cnt_d = '0;
      replay_pc_d  = oldest_pc;
    end
  end

  // Write-to-r0 is recorded as a non-writer so r0 never shows busy or hazards.
  always_comb begin
    v_d      = '0;
    wr_d     = '0;
    rd_d[0]  = id_rd;
    pc_d[0]  = id_pc;
    v_d[0]   = issue_w;
    wr_d[0]  = id_wr & (id_rd != '0);
    for (int k = 1; k < DEPTH; k++) begin
      v_d[k]  = v_q[k-1];
      wr_d[k] = wr_q[k-1];
      rd_d[k] = rd_q[k-1];
      pc_d[k] = pc_q[k-1];
    end
    if (err) begin
      v_d  = '0;
      wr_d = '0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_w && id_valid && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= ST_RUN;
      shadow_cnt_q <= '0;
      v_q          <= '0;
      wr_q         <= '0;
      replay_pc_q  <= '0;
      stall_cnt_q  <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        rd_q[k] <= '0;
        pc_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      shadow_cnt_q <= shadow_cnt_d;
      v_q          <= v_d;
      wr_q         <= wr_d;
      replay_pc_q  <= replay_pc_d;
      stall_cnt_q  <= stall_cnt_d;
      for (int k = 0; k < DEPTH; k++) begin
        rd_q[k] <= rd_d[k];
        pc_q[k] <= pc_d[k];
      end
    end
  end

  // issue/stall are combinational, so they are masked by reset to read 0
  // the instant arst_n drops regardless of the decode inputs.
  assign issue        = arst_n & issue_w;
  assign stall        = arst_n & stall_w;
  assign replay_valid = (state_q == ST_REPLAY);
  assign replay_pc    = replay_pc_q;
  assign busy_vec     = busy_w;
  assign stall_cnt    = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pipe_hazard_scoreboard: directed vector table plus reset/saturation   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_pipe_hazard_scoreboard;

  localparam int AW  = 5;
  localparam int PCW = 32;
  localparam int CW  = 4;
  localparam int NV  = 34;

  logic            clk = 1'b0;
  logic            arst_n;
  logic            id_valid, id_use_rs, id_use_rt, id_wr, id_branch, err;
  logic [AW-1:0]   id_rs, id_rt, id_rd;
  logic [PCW-1:0]  id_pc;
  logic            issue, stall, replay_valid;
  logic [PCW-1:0]  replay_pc;
  logic [31:0]     busy_vec;
  logic [CW-1:0]   stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  pipe_hazard_scoreboard #(
    .AW(AW), .PCW(PCW), .DEPTH(3), .BR_SHADOW(3), .STALL_CNT_W(CW)
  ) dut (
    .clk(clk), .arst_n(arst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr(id_wr), .id_rd(id_rd),
    .id_branch(id_branch), .id_pc(id_pc), .err(err), .issue(issue), .stall(stall),
    .replay_valid(replay_valid), .replay_pc(replay_pc), .busy_vec(busy_vec),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic        use_rs;
    logic [4:0]  rs;
    logic        use_rt;
    logic [4:0]  rt;
    logic        wr;
    logic [4:0]  rd;
    logic        br;
    logic [31:0] pc;
    logic        err;
    logic        e_issue;
    logic        e_stall;
    logic        e_rv;
    logic [31:0] e_rpc;
    logic [31:0] e_busy;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(logic v, logic urs, logic [4:0] rs, logic urt, logic [4:0] rt,
                              logic wr, logic [4:0] rd, logic br, logic [31:0] pc, logic e,
                              logic ei, logic es, logic erv, logic [31:0] erpc, logic [31:0] eb);
    mk = '{v, urs, rs, urt, rt, wr, rd, br, pc, e, ei, es, erv, erpc, eb};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic urs, input logic [4:0] rs, input logic urt,
                       input logic [4:0] rt, input logic wr, input logic [4:0] rd,
                       input logic br, input logic [31:0] pc, input logic e);
    id_valid = v;  id_use_rs = urs; id_rs = rs; id_use_rt = urt; id_rt = rt;
    id_wr = wr;    id_rd = rd;      id_branch = br; id_pc = pc;   err = e;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " issue"},     64'(issue),        64'd0);
    chk({tag, " stall"},     64'(stall),        64'd0);
    chk({tag, " replay_v"},  64'(replay_valid), 64'd0);
    chk({tag, " replay_pc"}, 64'(replay_pc),    64'd0);
    chk({tag, " busy_vec"},  64'(busy_vec),     64'd0);
    chk({tag, " stall_cnt"}, 64'(stall_cnt),    64'd0);
  endtask

  initial begin
    // dependency on r3, r0 writes, use_rt hazard, id_valid gating
    vecs[0]  = mk(1,0,0,0,0,1,3,0,32'h100,0, 1,0,0,0,32'h0);
    vecs[1]  = mk(1,1,3,0,0,0,0,0,32'h104,0, 0,1,0,0,32'h8);
    vecs[2]  = mk(1,1,3,0,0,0,0,0,32'h104,0, 0,1,0,0,32'h8);
    vecs[3]  = mk(1,1,3,0,0,0,0,0,32'h104,0, 0,1,0,0,32'h8);
    vecs[4]  = mk(1,1,3,0,0,0,0,0,32'h104,0, 1,0,0,0,32'h0);
    vecs[5]  = mk(1,0,0,0,0,1,0,0,32'h108,0, 1,0,0,0,32'h0);
    vecs[6]  = mk(1,1,0,1,0,0,0,0,32'h10c,0, 1,0,0,0,32'h0);
    vecs[7]  = mk(1,0,0,0,0,1,5,0,32'h110,0, 1,0,0,0,32'h0);
    vecs[8]  = mk(1,1,3,1,5,0,0,0,32'h114,0, 0,1,0,0,32'h20);
    vecs[9]  = mk(1,0,5,0,5,0,0,0,32'h118,0, 1,0,0,0,32'h20);
    vecs[10] = mk(0,1,5,0,0,0,0,0,32'h11c,0, 0,0,0,0,32'h20);
    vecs[11] = mk(0,0,0,0,0,0,0,0,32'h11c,0, 0,0,0,0,32'h0);
    // branch shadow of three cycles
    vecs[12] = mk(1,0,0,0,0,0,0,1,32'h200,0, 1,0,0,0,32'h0);
    vecs[13] = mk(1,0,0,0,0,0,0,0,32'h204,0, 0,1,0,0,32'h0);
    vecs[14] = mk(1,0,0,0,0,0,0,0,32'h204,0, 0,1,0,0,32'h0);
    vecs[15] = mk(1,0,0,0,0,0,0,0,32'h204,0, 0,1,0,0,32'h0);
    vecs[16] = mk(1,0,0,0,0,0,0,0,32'h204,0, 1,0,0,0,32'h0);
    // three in flight then err: replay oldest
    vecs[17] = mk(1,0,0,0,0,1,1,0,32'h10,0,  1,0,0,0,32'h0);
    vecs[18] = mk(1,0,0,0,0,1,2,0,32'h14,0,  1,0,0,0,32'h2);
    vecs[19] = mk(1,0,0,0,0,1,4,0,32'h18,0,  1,0,0,0,32'h6);
    vecs[20] = mk(1,0,0,0,0,0,0,0,32'h1c,1,  0,1,0,0,32'h16);
    vecs[21] = mk(1,0,0,0,0,0,0,0,32'h1c,0,  0,1,1,32'h10,32'h0);
    vecs[22] = mk(1,0,0,0,0,0,0,0,32'h1c,0,  1,0,0,0,32'h0);
    // err with branch: no shadow; only E[0] valid
    vecs[23] = mk(1,0,0,0,0,0,0,1,32'h300,1, 0,1,0,0,32'h0);
    vecs[24] = mk(1,0,0,0,0,0,0,0,32'h300,0, 0,1,1,32'h1c,32'h0);
    vecs[25] = mk(1,0,0,0,0,0,0,0,32'h300,0, 1,0,0,0,32'h0);
    // err during replay restarts it with id_pc
    vecs[26] = mk(1,0,0,0,0,0,0,0,32'h400,1, 0,1,0,0,32'h0);
    vecs[27] = mk(1,0,0,0,0,0,0,0,32'h404,1, 0,1,1,32'h300,32'h0);
    vecs[28] = mk(1,0,0,0,0,0,0,0,32'h408,0, 0,1,1,32'h404,32'h0);
    vecs[29] = mk(1,0,0,0,0,0,0,0,32'h408,0, 1,0,0,0,32'h0);
    // err while a dependent waits; oldest valid is E[1]
    vecs[30] = mk(1,0,0,0,0,1,7,0,32'h500,0, 1,0,0,0,32'h0);
    vecs[31] = mk(1,1,7,0,0,0,0,0,32'h504,1, 0,1,0,0,32'h80);
    vecs[32] = mk(1,1,7,0,0,0,0,0,32'h504,0, 0,1,1,32'h408,32'h0);
    vecs[33] = mk(1,1,7,0,0,0,0,0,32'h504,0, 1,0,0,0,32'h0);

    arst_n = 1'b0;
    drive(0,0,0,0,0,0,0,0,32'h0,0);
    #1;
    chk_all_zero("reset");
    #12 arst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i].valid, vecs[i].use_rs, vecs[i].rs, vecs[i].use_rt, vecs[i].rt,
            vecs[i].wr, vecs[i].rd, vecs[i].br, vecs[i].pc, vecs[i].err);
      @(negedge clk);
      chk($sformatf("v%0d issue", i),    64'(issue),        64'(vecs[i].e_issue));
      chk($sformatf("v%0d stall", i),    64'(stall),        64'(vecs[i].e_stall));
      chk($sformatf("v%0d replay_v", i), 64'(replay_valid), 64'(vecs[i].e_rv));
      chk($sformatf("v%0d busy", i),     64'(busy_vec),     64'(vecs[i].e_busy));
      if (vecs[i].e_rv)
        chk($sformatf("v%0d replay_pc", i), 64'(replay_pc), 64'(vecs[i].e_rpc));
    end

    // asynchronous reset mid-cycle clears everything
    @(posedge clk);
    #1 drive(0,0,0,0,0,0,0,0,32'h0,0);
    #2 arst_n = 1'b0;
    #1 chk_all_zero("reset2");
    @(negedge clk);
    arst_n = 1'b1;

    // 7 x (producer + 3 dependent stalls) = 21 stalls; counter saturates at 15
    for (int it = 0; it < 7; it++) begin
      @(posedge clk);
      #1;
      if (it == 1) chk("stall_cnt after 3", 64'(stall_cnt), 64'd3);
      if (it == 5) chk("stall_cnt after 15", 64'(stall_cnt), 64'd15);
      drive(1,0,0,0,0,1,3,0,32'h600,0);
      for (int s = 0; s < 3; s++) begin
        @(posedge clk);
        #1 drive(1,1,3,0,0,0,0,0,32'h604,0);
      end
    end
    @(posedge clk);
    #1;
    chk("stall_cnt saturated", 64'(stall_cnt), 64'd15);

    drive(1,0,0,0,0,1,3,0,32'h700,0);
    @(posedge clk);
    #1 drive(1,1,3,0,0,0,0,0,32'h704,0);
    #1 chk("pre-reset stall", 64'(stall), 64'd1);
    chk("pre-reset busy", 64'(busy_vec), 64'h8);
    #1 arst_n = 1'b0;
    #1 chk_all_zero("reset_mid_stall");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
